// File: rtl/addmul_rr_scheduler_if.sv
// Request/response bundle for addmul_rr_scheduler.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/b/c           : packed operands, requester i owns [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake towards the single consumer
//   rsp_id/sum/prod     : result payload tagged with the owning requester
//   busy                : any pipeline stage holds a valid operation
// slave modport = the scheduler; master modport = requesters + consumer.
interface addmul_rr_scheduler_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic [2*WIDTH-1:0]       rsp_prod;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_prod, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_prod, busy
  );
endinterface

// File: rtl/addmul_rr_scheduler.sv
// Round-robin scheduler in front of a shared 2-stage add-multiply datapath.
//   clk, rst : clock and synchronous active-high reset
//   bus      : addmul_rr_scheduler_if.slave (requests in, tagged results out)
// Stage p1 captures the granted operands and requester id; stage p2 holds
// sum = a+b (mod 2^WIDTH) and prod = sum*c (full 2*WIDTH bits). A stalled
// output (rsp_valid & ~rsp_ready) freezes both stages and blocks all grants.
module addmul_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  addmul_rr_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  function automatic logic [WIDTH-1:0] wrap_sum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    return x + y;
  endfunction

  function automatic logic [2*WIDTH-1:0] full_prod(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    return {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
  endfunction

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0]   a_p1_q, a_p1_d;
  logic [WIDTH-1:0]   b_p1_q, b_p1_d;
  logic [WIDTH-1:0]   c_p1_q, c_p1_d;
  logic [ID_W-1:0]    id_p1_q, id_p1_d;
  logic               vld_p2_q, vld_p2_d;
  logic [ID_W-1:0]    id_p2_q, id_p2_d;
  logic [WIDTH-1:0]   sum_p2_q, sum_p2_d;
  logic [2*WIDTH-1:0] prod_p2_q, prod_p2_d;

  logic               stall;
  logic               found;
  logic               xfer;
  logic [ID_W-1:0]    gnt;
  logic [WIDTH-1:0]   a_sel, b_sel, c_sel;
  logic [WIDTH-1:0]   sum_p1;
  int                 scan_idx;

  always_comb begin
    stall    = vld_p2_q & ~bus.rsp_ready;
    found    = 1'b0;
    gnt      = ptr_q;
    a_sel    = '0;
    b_sel    = '0;
    c_sel    = '0;
    scan_idx = 0;
    // Scan starts just after the last winner, so the previous grantee has
    // lowest priority this cycle.
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[scan_idx]) begin
        found = 1'b1;
        gnt   = ID_W'(scan_idx);
        a_sel = bus.req_a[scan_idx*WIDTH +: WIDTH];
        b_sel = bus.req_b[scan_idx*WIDTH +: WIDTH];
        c_sel = bus.req_c[scan_idx*WIDTH +: WIDTH];
      end
    end
    xfer          = found & ~stall & ~rst;
    bus.req_ready = xfer ? (NUM_REQ'(1) << gnt) : '0;
  end

  always_comb begin
    sum_p1    = wrap_sum(a_p1_q, b_p1_q);
    ptr_d     = xfer ? gnt : ptr_q;
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    c_p1_d    = c_p1_q;
    id_p1_d   = id_p1_q;
    vld_p2_d  = vld_p2_q;
    id_p2_d   = id_p2_q;
    sum_p2_d  = sum_p2_q;
    prod_p2_d = prod_p2_q;
    if (!stall) begin
      // Stage p1: capture granted operation
      vld_p1_d = xfer;
      if (xfer) begin
        a_p1_d  = a_sel;
        b_p1_d  = b_sel;
        c_p1_d  = c_sel;
        id_p1_d = gnt;
      end
      // Stage p2: add, multiply, present result
      vld_p2_d  = vld_p1_q;
      id_p2_d   = id_p1_q;
      sum_p2_d  = sum_p1;
      prod_p2_d = full_prod(sum_p1, c_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= ID_W'(NUM_REQ - 1);
      vld_p1_q  <= 1'b0;
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      c_p1_q    <= '0;
      id_p1_q   <= '0;
      vld_p2_q  <= 1'b0;
      id_p2_q   <= '0;
      sum_p2_q  <= '0;
      prod_p2_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_p1_q  <= vld_p1_d;
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      c_p1_q    <= c_p1_d;
      id_p1_q   <= id_p1_d;
      vld_p2_q  <= vld_p2_d;
      id_p2_q   <= id_p2_d;
      sum_p2_q  <= sum_p2_d;
      prod_p2_q <= prod_p2_d;
    end
  end

  assign bus.rsp_valid = vld_p2_q;
  assign bus.rsp_id    = id_p2_q;
  assign bus.rsp_sum   = sum_p2_q;
  assign bus.rsp_prod  = prod_p2_q;
  assign bus.busy      = vld_p1_q | vld_p2_q;
endmodule

// File: tb/tb_addmul_rr_scheduler.sv
// Scoreboard bench for addmul_rr_scheduler: per-requester vector queues feed
// the DUT, each accepted vector pushes its hand-computed result into the
// scoreboard, and an independent monitor pops/compares every delivered result.
module tb_addmul_rr_scheduler;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0]   a, b, c, s;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    int             id;
    logic [W-1:0]   s;
    logic [2*W-1:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addmul_rr_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  addmul_rr_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t req_q[N][$];
  exp_t sb[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  int   rsp_cyc[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  exp_t obs_e, mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic enq(input int i, input int a, input int b, input int c, input int s, input int p);
    vec_t v;
    v.a = W'(a); v.b = W'(b); v.c = W'(c); v.s = W'(s); v.p = (2*W)'(p);
    req_q[i].push_back(v);
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*W +: W]    = req_q[i][0].a;
        bus.req_b[i*W +: W]    = req_q[i][0].b;
        bus.req_c[i*W +: W]    = req_q[i][0].c;
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_a[i*W +: W]    = 8'hA5;
        bus.req_b[i*W +: W]    = 8'h5A;
        bus.req_c[i*W +: W]    = 8'h3C;
      end
    end
  endtask

  function automatic bit pending();
    bit any = 0;
    for (int i = 0; i < N; i++) if (req_q[i].size() > 0) any = 1;
    return any || (sb.size() > 0) || (bus.busy === 1'b1);
  endfunction

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    do begin
      drive_cycle();
      n++;
    end while (pending() && n < max_cyc);
    check({name, "_drained"}, 32'(pending()), 0);
  endtask

  task automatic check_grants(input string name, input int n, input int e[8]);
    check({name, "_grant_count"}, 32'(gnt_log.size()), 32'(n));
    for (int k = 0; k < n; k++)
      if (k < gnt_log.size()) check({name, "_grant"}, 32'(gnt_log[k]), 32'(e[k]));
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    rsp_cyc.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Request-side observer: every accepted vector becomes an expectation.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] === 1'b1 && bus.req_ready[i] === 1'b1 && req_q[i].size() > 0) begin
        obs_e.id = i;
        obs_e.s  = req_q[i][0].s;
        obs_e.p  = req_q[i][0].p;
        sb.push_back(obs_e);
        void'(req_q[i].pop_front());
        gnt_log.push_back(i);
        gnt_cyc.push_back(cyc);
      end
    end
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
  end

  // Response monitor.
  initial begin : monitor
    bit             prev_stall = 0;
    logic [1:0]     prev_id;
    logic [W-1:0]   prev_sum;
    logic [2*W-1:0] prev_prod;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 32'(bus.rsp_valid), 1);
          check("stall_hold_id", 32'(bus.rsp_id), 32'(prev_id));
          check("stall_hold_sum", 32'(bus.rsp_sum), 32'(prev_sum));
          check("stall_hold_prod", 32'(bus.rsp_prod), 32'(prev_prod));
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b0) begin
          check("stall_ready_zero", 32'(bus.req_ready), 0);
          stall_cnt++;
          prev_stall = 1;
          prev_id    = bus.rsp_id;
          prev_sum   = bus.rsp_sum;
          prev_prod  = bus.rsp_prod;
        end else begin
          prev_stall = 0;
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
          rsp_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp id=%0d sum=%0d prod=%0d required=no response",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_prod);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
            check("rsp_sum", 32'(bus.rsp_sum), 32'(mon_e.s));
            check("rsp_prod", 32'(bus.rsp_prod), 32'(mon_e.p));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e[8];
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_req_ready", 32'(bus.req_ready), 0);
    check("reset_rsp_id", 32'(bus.rsp_id), 0);
    check("reset_rsp_sum", 32'(bus.rsp_sum), 0);
    check("reset_rsp_prod", 32'(bus.rsp_prod), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op from requester 2.
    clear_logs();
    enq(2, 10, 20, 5, 30, 150);
    drain("single", 50);
    e = '{2, 0, 0, 0, 0, 0, 0, 0};
    check_grants("single", 1, e);
    if (gnt_cyc.size() > 0 && rsp_cyc.size() > 0)
      check("single_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 2);
    else check("single_latency_seen", 32'(rsp_cyc.size()), 1);

    // Wrap-around sum and maximum product.
    clear_logs();
    enq(0, 200, 100, 3, 44, 132);
    enq(0, 255, 0, 255, 255, 65025);
    drain("wrap", 50);
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_grants("wrap", 2, e);

    // Idle: nothing requested, nothing moves, pointer stays at 0.
    repeat (10) begin
      drive_cycle();
      @(negedge clk);
      check("idle_req_ready", 32'(bus.req_ready), 0);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      check("idle_busy", 32'(bus.busy), 0);
    end
    clear_logs();
    enq(0, 3, 4, 5, 7, 35);
    enq(1, 6, 7, 8, 13, 104);
    enq(2, 9, 10, 11, 19, 209);
    enq(3, 12, 13, 14, 25, 350);
    drain("idle_next", 50);
    e = '{1, 2, 3, 0, 0, 0, 0, 0};
    check_grants("idle_next", 4, e);

    // Reset with one op in each stage.
    clear_logs();
    enq(1, 1, 2, 3, 3, 9);
    enq(1, 4, 5, 6, 9, 54);
    drive_cycle();
    drive_cycle();
    drive_cycle();
    check("midflight_rsp_valid", 32'(bus.rsp_valid), 1);
    check("midflight_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("post_reset_busy", 32'(bus.busy), 0);

    // Round-robin with all requesters continuously valid.
    clear_logs();
    enq(0, 1, 1, 1, 2, 2);
    enq(0, 100, 100, 2, 200, 400);
    enq(1, 2, 3, 4, 5, 20);
    enq(1, 128, 128, 9, 0, 0);
    enq(2, 7, 8, 9, 15, 135);
    enq(2, 50, 60, 70, 110, 7700);
    enq(3, 255, 255, 255, 254, 64770);
    enq(3, 16, 16, 16, 32, 512);
    drain("rr", 100);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_grants("rr", 8, e);
    check("rr_rsp_count", 32'(rsp_cyc.size()), 8);
    for (int k = 1; k < 8; k++)
      if (k < rsp_cyc.size()) check("rr_rsp_consecutive", 32'(rsp_cyc[k] - rsp_cyc[0]), 32'(k));

    // Backpressure: 5 cycles of rsp_ready low mid-stream.
    clear_logs();
    stall_cnt = 0;
    enq(1, 10, 1, 2, 11, 22);
    enq(1, 20, 2, 3, 22, 66);
    enq(1, 30, 3, 4, 33, 132);
    enq(3, 40, 4, 5, 44, 220);
    enq(3, 50, 5, 6, 55, 330);
    enq(3, 60, 6, 7, 66, 462);
    drive_cycle();
    drive_cycle();
    drive_cycle();
    bus.rsp_ready = 1'b0;
    repeat (5) drive_cycle();
    bus.rsp_ready = 1'b1;
    drain("bp", 100);
    e = '{1, 3, 1, 3, 1, 3, 0, 0};
    check_grants("bp", 6, e);
    check("bp_stall_cycles", 32'(stall_cnt), 5);
    check("bp_rsp_count", 32'(rsp_cyc.size()), 6);
    check("bp_sb_empty", 32'(sb.size()), 0);

    repeat (3) drive_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
